// File: rtl/window_3x3_gen.sv
// 3x3 neighbourhood window generator: two line buffers feed a shifting 3x3 register array.
// Latency: the window completed by pixel (r,c) is on p0..p8 the cycle after its accepting edge.
// Backpressure: none; every pix_valid pixel is consumed, and the outputs hold while idle.
module window_3x3_gen #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DW-1:0]            pix_in,
    input  logic                     pix_valid,
    output logic [DW-1:0]            p0,
    output logic [DW-1:0]            p1,
    output logic [DW-1:0]            p2,
    output logic [DW-1:0]            p3,
    output logic [DW-1:0]            p4,
    output logic [DW-1:0]            p5,
    output logic [DW-1:0]            p6,
    output logic [DW-1:0]            p7,
    output logic [DW-1:0]            p8,
    output logic                     win_valid,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
    output logic                     win_last
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    // Raster position of the pixel currently presented on pix_in.
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // lb_top holds row r-2, lb_mid holds row r-1, indexed by column.
    logic [DW-1:0] lb_top [IMG_W];
    logic [DW-1:0] lb_mid [IMG_W];

    logic [DW-1:0] top_rd;
    logic [DW-1:0] mid_rd;
    logic          accept;
    logic          col_end;
    logic          row_end;
    logic          interior;

    assign accept   = pix_valid && !rst;
    assign col_end  = (col == CW'(IMG_W - 1));
    assign row_end  = (row == RW'(IMG_H - 1));
    // Windows touching rows 0-1 carry stale line-buffer data; columns 0-1 wrap from the previous row.
    assign interior = (row >= RW'(2)) && (col >= CW'(2));

    // Combinational read sees the value before this cycle's write lands (read-before-write).
    assign top_rd = lb_top[col];
    assign mid_rd = lb_mid[col];

    // Column/row counters advance only on accepted pixels; a row wrap starts the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (pix_valid) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line buffers roll down one row per column: mid moves to top, the new pixel goes to mid.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_top[col] <= mid_rd;
            lb_mid[col] <= pix_in;
        end
    end

    // Window shift and emission; strobes are single-cycle, data and coordinates hold while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            p0        <= '0;
            p1        <= '0;
            p2        <= '0;
            p3        <= '0;
            p4        <= '0;
            p5        <= '0;
            p6        <= '0;
            p7        <= '0;
            p8        <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            if (pix_valid) begin
                p0 <= p1;
                p1 <= p2;
                p2 <= top_rd;
                p3 <= p4;
                p4 <= p5;
                p5 <= mid_rd;
                p6 <= p7;
                p7 <= p8;
                p8 <= pix_in;
                if (interior) begin
                    win_valid <= 1'b1;
                    win_last  <= row_end && col_end;
                    win_row   <= row - RW'(1);
                    win_col   <= col - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_window_3x3_gen.sv
module tb_window_3x3_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 0: 4x4 frame
    logic       rst0 = 1'b1, vld0 = 1'b0;
    logic [7:0] pix0 = '0;
    logic [7:0] q0 [9];
    logic       wv0, wl0;
    logic [1:0] wr0, wc0;

    // DUT 1: 5 wide x 4 high frame
    logic       rst1 = 1'b1, vld1 = 1'b0;
    logic [7:0] pix1 = '0;
    logic [7:0] q1 [9];
    logic       wv1, wl1;
    logic [1:0] wr1;
    logic [2:0] wc1;

    // DUT 2: default 128x128 frame
    logic       rst2 = 1'b1, vld2 = 1'b0;
    logic [7:0] pix2 = '0;
    logic [7:0] q2 [9];
    logic       wv2, wl2;
    logic [6:0] wr2, wc2;

    window_3x3_gen #(.IMG_W(4), .IMG_H(4), .DW(8)) dut0 (
        .clk(clk), .rst(rst0), .pix_in(pix0), .pix_valid(vld0),
        .p0(q0[0]), .p1(q0[1]), .p2(q0[2]), .p3(q0[3]), .p4(q0[4]),
        .p5(q0[5]), .p6(q0[6]), .p7(q0[7]), .p8(q0[8]),
        .win_valid(wv0), .win_row(wr0), .win_col(wc0), .win_last(wl0)
    );

    window_3x3_gen #(.IMG_W(5), .IMG_H(4), .DW(8)) dut1 (
        .clk(clk), .rst(rst1), .pix_in(pix1), .pix_valid(vld1),
        .p0(q1[0]), .p1(q1[1]), .p2(q1[2]), .p3(q1[3]), .p4(q1[4]),
        .p5(q1[5]), .p6(q1[6]), .p7(q1[7]), .p8(q1[8]),
        .win_valid(wv1), .win_row(wr1), .win_col(wc1), .win_last(wl1)
    );

    window_3x3_gen dut2 (
        .clk(clk), .rst(rst2), .pix_in(pix2), .pix_valid(vld2),
        .p0(q2[0]), .p1(q2[1]), .p2(q2[2]), .p3(q2[3]), .p4(q2[4]),
        .p5(q2[5]), .p6(q2[6]), .p7(q2[7]), .p8(q2[8]),
        .win_valid(wv2), .win_row(wr2), .win_col(wc2), .win_last(wl2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: raster position of the next pixel and the last emitted window.
    int         mr = 0, mc = 0;
    int         base = 0;
    int         mode = 0;
    bit         have_hold = 1'b0;
    logic [7:0] hp [9];
    int         hrow = 0, hcol = 0;
    int         wins = 0, lasts = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pixval(input int r, input int c);
        int v;
        if (mode == 0) v = base + 16 * r + c;
        else           v = (3 * r + c) % 256;
        return v[7:0];
    endfunction

    task automatic sample(input int sel, output logic [7:0] ob [9], output logic ov, output logic ol,
                          output int orow, output int ocol);
        case (sel)
            0: begin ob = q0; ov = wv0; ol = wl0; orow = int'(wr0); ocol = int'(wc0); end
            1: begin ob = q1; ov = wv1; ol = wl1; orow = int'(wr1); ocol = int'(wc1); end
            default: begin ob = q2; ov = wv2; ol = wl2; orow = int'(wr2); ocol = int'(wc2); end
        endcase
    endtask

    // One clock on the selected DUT: present a pixel (or a bubble) and check the next-cycle outputs.
    task automatic drive(input int sel, input bit vld);
        logic [7:0] px;
        logic [7:0] ob [9];
        logic       ov, ol;
        int         orow, ocol, w, h;
        bit         ew, el;
        w  = (sel == 1) ? 5 : (sel == 2) ? 128 : 4;
        h  = (sel == 2) ? 128 : 4;
        px = pixval(mr, mc);
        @(negedge clk);
        case (sel)
            0: begin vld0 = vld; pix0 = px; end
            1: begin vld1 = vld; pix1 = px; end
            default: begin vld2 = vld; pix2 = px; end
        endcase
        ew = vld && mr >= 2 && mc >= 2;
        el = ew && mr == h - 1 && mc == w - 1;
        @(posedge clk);
        #1;
        vld0 = 1'b0; vld1 = 1'b0; vld2 = 1'b0;
        sample(sel, ob, ov, ol, orow, ocol);
        chk("win_valid", {31'd0, ov}, {31'd0, ew});
        chk("win_last", {31'd0, ol}, {31'd0, el});
        if (ov) wins++;
        if (ol) lasts++;
        if (ew) begin
            for (int k = 0; k < 9; k++) begin
                hp[k] = pixval(mr - 2 + k / 3, mc - 2 + k % 3);
                chk($sformatf("p%0d", k), {24'd0, ob[k]}, {24'd0, hp[k]});
            end
            hrow = mr - 1;
            hcol = mc - 1;
            chk("win_row", orow, hrow);
            chk("win_col", ocol, hcol);
            have_hold = 1'b1;
        end else if (!vld && have_hold) begin
            for (int k = 0; k < 9; k++)
                chk($sformatf("hold_p%0d", k), {24'd0, ob[k]}, {24'd0, hp[k]});
            chk("hold_row", orow, hrow);
            chk("hold_col", ocol, hcol);
        end
        if (vld) begin
            if (!ew) have_hold = 1'b0;
            if (mc == w - 1) begin
                mc = 0;
                mr = (mr == h - 1) ? 0 : mr + 1;
            end else begin
                mc = mc + 1;
            end
        end
    endtask

    // Reset the selected DUT for one edge (optionally with pix_valid high) and check all outputs clear.
    task automatic do_reset(input int sel, input bit vld);
        logic [7:0] ob [9];
        logic       ov, ol;
        int         orow, ocol;
        @(negedge clk);
        case (sel)
            0: begin rst0 = 1'b1; vld0 = vld; pix0 = 8'hff; end
            1: begin rst1 = 1'b1; vld1 = vld; pix1 = 8'hff; end
            default: begin rst2 = 1'b1; vld2 = vld; pix2 = 8'hff; end
        endcase
        @(posedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        vld0 = 1'b0; vld1 = 1'b0; vld2 = 1'b0;
        sample(sel, ob, ov, ol, orow, ocol);
        chk("rst_win_valid", {31'd0, ov}, 32'd0);
        chk("rst_win_last", {31'd0, ol}, 32'd0);
        chk("rst_win_row", orow, 0);
        chk("rst_win_col", ocol, 0);
        for (int k = 0; k < 9; k++)
            chk($sformatf("rst_p%0d", k), {24'd0, ob[k]}, 32'd0);
        mr = 0;
        mc = 0;
        have_hold = 1'b0;
    endtask

    task automatic frame(input int sel, input int w, input int h, input bit bubbles);
        for (int n = 0; n < w * h; n++) begin
            if (bubbles) begin
                for (int g = 0; g < 3; g++)
                    if ($urandom_range(0, 1) == 1) drive(sel, 1'b0);
            end
            drive(sel, 1'b1);
        end
        // Trailing bubble exercises the single-cycle strobe and hold of the final window.
        drive(sel, 1'b0);
    endtask

    initial begin
        // Reset state of every instance
        do_reset(1, 1'b0);
        do_reset(2, 1'b0);
        do_reset(0, 1'b0);

        // Basic 4x4 frame, continuous
        mode = 0; base = 0; wins = 0; lasts = 0;
        frame(0, 4, 4, 1'b0);
        chk("basic_windows", wins, 4);
        chk("basic_lasts", lasts, 1);

        // Same frame with random bubbles
        wins = 0; lasts = 0;
        frame(0, 4, 4, 1'b1);
        chk("bubble_windows", wins, 4);
        chk("bubble_lasts", lasts, 1);

        // Borders on a 5x4 frame
        wins = 0; lasts = 0; mr = 0; mc = 0; have_hold = 1'b0;
        frame(1, 5, 4, 1'b0);
        chk("border_windows", wins, 6);
        chk("border_lasts", lasts, 1);

        // Back-to-back frames, second frame offset by 0x80
        wins = 0; lasts = 0; mr = 0; mc = 0; have_hold = 1'b0;
        base = 0;
        for (int n = 0; n < 16; n++) drive(0, 1'b1);
        base = 8'h80;
        for (int n = 0; n < 16; n++) drive(0, 1'b1);
        drive(0, 1'b0);
        chk("b2b_windows", wins, 8);
        chk("b2b_lasts", lasts, 2);

        // Reset mid-frame: partial frame then one reset edge with pix_valid high
        base = 0;
        for (int n = 0; n < 7; n++) drive(0, 1'b1);
        do_reset(0, 1'b1);
        wins = 0; lasts = 0;
        frame(0, 4, 4, 1'b0);
        chk("midrst_windows", wins, 4);
        chk("midrst_lasts", lasts, 1);

        // Default 128x128 frame
        mode = 1; wins = 0; lasts = 0; mr = 0; mc = 0; have_hold = 1'b0;
        frame(2, 128, 128, 1'b0);
        chk("default_windows", wins, 15876);
        chk("default_lasts", lasts, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
